// File: rtl/rate_sel_ctrl.sv
// rate_sel_ctrl: button-stepped 2-bit rate select, divide-count mapping and slow tick generator.
// Define AUTO_SWEEP_EN to compile in the automatic rate sweep (dwell counter driven by auto_en).
module rate_sel_ctrl #(
  parameter logic [31:0] DIV0  = 32'd25000000,
  parameter logic [31:0] DIV1  = 32'd12500000,
  parameter logic [31:0] DIV2  = 32'd8333333,
  parameter logic [31:0] DIV3  = 32'd6250000,
  parameter int unsigned DWELL = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        auto_en,
  output logic [1:0]  sel,
  output logic [31:0] div_n,
  output logic        tick,
  output logic [3:0]  rate_led
);

  logic [1:0]  sel_q, sel_d;
  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        up_q, up_d;
  logic        dn_q, dn_d;
  logic        rise_up, rise_dn;
  logic        step_up, step_dn;
  logic        wrap;

`ifdef AUTO_SWEEP_EN
  localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
  logic [31:0] dcnt_q, dcnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = auto_en ^ (DWELL == 0);
`endif

  always_comb begin
    unique case (sel_q)
      2'd0:    div_n = DIV0;
      2'd1:    div_n = DIV1;
      2'd2:    div_n = DIV2;
      default: div_n = DIV3;
    endcase
  end

  assign sel      = sel_q;
  assign tick     = tick_q;
  assign rate_led = 4'b0001 << sel_q;

  // cnt never exceeds div_n-1, so cnt+1 cannot overflow and compares directly against div_n.
  always_comb begin
    up_d    = btn_up;
    dn_d    = btn_dn;
    rise_up = btn_up & ~up_q;
    rise_dn = btn_dn & ~dn_q;
    step_up = rise_up & ~rise_dn;
    step_dn = rise_dn & ~rise_up;
    wrap    = ((cnt_q + 32'd1) == div_n);

    sel_d  = sel_q;
    cnt_d  = wrap ? 32'd0 : cnt_q + 32'd1;
    tick_d = wrap;

`ifdef AUTO_SWEEP_EN
    dcnt_d = auto_en ? dcnt_q : 32'd0;
    if (auto_en && wrap) begin
      if (dcnt_q == DWELL_LAST) begin
        sel_d  = sel_q + 2'd1;
        dcnt_d = 32'd0;
      end else begin
        dcnt_d = dcnt_q + 32'd1;
      end
    end
`endif

    // A button step outranks the sweep and restarts the period without emitting a tick.
    if (step_up || step_dn) begin
      sel_d  = step_up ? sel_q + 2'd1 : sel_q - 2'd1;
      cnt_d  = 32'd0;
      tick_d = 1'b0;
`ifdef AUTO_SWEEP_EN
      dcnt_d = 32'd0;
`endif
    end
  end

  // Button history resets high so a button held through reset does not count as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= 2'd0;
      cnt_q  <= 32'd0;
      tick_q <= 1'b0;
      up_q   <= 1'b1;
      dn_q   <= 1'b1;
`ifdef AUTO_SWEEP_EN
      dcnt_q <= 32'd0;
`endif
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      up_q   <= up_d;
      dn_q   <= dn_d;
`ifdef AUTO_SWEEP_EN
      dcnt_q <= dcnt_d;
`endif
    end
  end

endmodule
